// File: rtl/bin_update_tx.sv
// Binned update transmitter: coalesces same-bin increments and emits
// {bin, value} words on a 64-bit AXI-Stream master port.
module bin_update_tx #(
  parameter int ABITS         = 7,
  parameter int DBITS         = 64,
  parameter int VBITS         = 32,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [ABITS-1:0] up_bin,
  input  logic [VBITS-1:0] up_value,
  input  logic             flush,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [DBITS-1:0] m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic [15:0]      word_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  localparam logic [7:0] AGE_MAX = 8'(FLUSH_TIMEOUT - 1);

  state_t           state_q;
  logic             ready_q;
  logic [ABITS-1:0] pbin_q;
  logic [VBITS-1:0] psum_q;
  logic [7:0]       age_q;
  logic             tvalid_q;
  logic             tlast_q;
  logic [DBITS-1:0] tdata_q;
  logic [15:0]      count_q;

  logic             out_free;
  logic             same_bin;
  logic             nz;
  logic             acc;
  logic [VBITS:0]   sum_d;
  logic [VBITS-1:0] sat_d;
  logic [8:0]       pbin9;
  logic [DBITS-1:0] pword;

  assign out_free = !tvalid_q | m_axis_tready;
  assign same_bin = up_bin == pbin_q;
  assign nz       = up_value != '0;

  // Zero updates never displace the pending entry, so they are always taken.
  assign up_ready = ready_q &&
    (state_q == IDLE ||
     (state_q == ACCUM && (same_bin || out_free || !nz)));

  assign acc   = up_valid & up_ready & nz;
  assign sum_d = {1'b0, psum_q} + {1'b0, up_value};
  assign sat_d = sum_d[VBITS] ? '1 : sum_d[VBITS-1:0];
  assign pbin9 = 9'(pbin_q);
  assign pword = DBITS'({pbin9, psum_q});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      pbin_q   <= '0;
      psum_q   <= '0;
      age_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      count_q  <= '0;
    end else begin
      ready_q <= 1'b1;
      if (tvalid_q & m_axis_tready) begin
        tvalid_q <= 1'b0;
        count_q  <= count_q + 16'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            pbin_q  <= up_bin;
            psum_q  <= up_value;
            age_q   <= '0;
            state_q <= flush ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (acc && same_bin) begin
            psum_q <= sat_d;
            age_q  <= '0;
          end else if (acc) begin
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tdata_q  <= pword;
            pbin_q   <= up_bin;
            psum_q   <= up_value;
            age_q    <= '0;
          end else if (age_q != AGE_MAX) begin
            age_q <= age_q + 8'd1;
          end else if (!flush && out_free) begin
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tdata_q  <= pword;
            state_q  <= IDLE;
          end
          // Flush outranks the timeout so the drained word carries tlast.
          if (flush) state_q <= DRAIN;
        end
        DRAIN: begin
          if (out_free) begin
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b1;
            tdata_q  <= pword;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign word_count    = count_q;
  assign busy = (state_q != IDLE) | tvalid_q | (state_q == DRAIN);

endmodule

// File: tb/tb_bin_update_tx.sv
// Scoreboard bench for bin_update_tx: directed updates push expected
// words, an independent monitor pops and checks every handshake.
module tb_bin_update_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        up_valid = 1'b0;
  logic        up_ready;
  logic [6:0]  up_bin = '0;
  logic [31:0] up_value = '0;
  logic        flush = 1'b0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        busy;
  logic [15:0] word_count;

  int tests = 0;
  int fails = 0;
  logic [64:0] exp_q[$];

  bin_update_tx dut (
    .clock(clock), .reset(reset),
    .up_valid(up_valid), .up_ready(up_ready),
    .up_bin(up_bin), .up_value(up_value), .flush(flush),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .word_count(word_count)
  );

  always #5 clock = ~clock;

  function automatic logic [64:0] w(input logic [8:0] b,
                                    input logic [31:0] v,
                                    input logic l);
    return {l, 23'b0, b, v};
  endfunction

  task automatic chk(input string nm, input logic [64:0] act,
                     input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops on every handshake and checks hold-stability.
  logic        hold_v = 1'b0;
  logic [64:0] hold_w;
  always @(negedge clock) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
            {1'b1, hold_w});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_word: got %h expected none",
                   {m_axis_tlast, m_axis_tdata});
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          tests--;
          chk("word", {m_axis_tlast, m_axis_tdata}, e);
        end
      end
      hold_v = m_axis_tvalid && !m_axis_tready;
      hold_w = {m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic upd(input logic [6:0] b, input logic [31:0] v);
    int n;
    @(posedge clock); #1;
    up_valid = 1'b1; up_bin = b; up_value = v;
    @(negedge clock);
    n = 0;
    while (!up_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL upd_timeout: got up_ready 0 expected 1");
    end
    @(posedge clock); #1;
    up_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(posedge clock); #1 flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL idle_timeout: got busy %0d pending %0d expected 0 0",
               busy, exp_q.size());
    end
  endtask

  initial begin
    logic saw;
    // Reset state
    #12;
    chk("rst_outputs",
        65'({up_ready, m_axis_tvalid, m_axis_tlast, busy, word_count}),
        65'd0);
    chk("rst_tdata", {1'b0, m_axis_tdata}, 65'd0);
    @(posedge clock); #1 reset = 1'b0;
    chk("ready_low_after_release", 65'(up_ready), 65'd0);
    @(posedge clock); #1;
    chk("ready_high_first_edge", 65'(up_ready), 65'd1);

    // Zero update and flush with nothing pending
    upd(7'd4, 32'd0);
    chk("zero_busy", 65'(busy), 65'd0);
    do_flush();
    repeat (3) @(posedge clock);
    #1;
    chk("zero_count", 65'(word_count), 65'd0);
    chk("zero_tvalid_busy", 65'({m_axis_tvalid, busy}), 65'd0);

    // Coalesce
    upd(7'd5, 32'd10);
    upd(7'd5, 32'd20);
    upd(7'd5, 32'd12);
    exp_q.push_back(w(9'd5, 32'd42, 1'b0));
    upd(7'd9, 32'd1);
    chk("coal_latency", {m_axis_tvalid, m_axis_tdata},
        {1'b1, 64'h0000_0005_0000_002A});
    @(posedge clock); #1;
    chk("coal_count", 65'(word_count), 65'd1);
    exp_q.push_back(w(9'd9, 32'd1, 1'b1));
    do_flush();
    wait_idle();

    // Saturation
    upd(7'd3, 32'hFFFF_FFF0);
    upd(7'd3, 32'h20);
    exp_q.push_back({1'b1, 64'h0000_0003_FFFF_FFFF});
    do_flush();
    wait_idle();

    // Backpressure
    m_axis_tready = 1'b0;
    exp_q.push_back(w(9'd1, 32'd1, 1'b0));
    exp_q.push_back(w(9'd2, 32'd1, 1'b0));
    upd(7'd1, 32'd1);
    upd(7'd2, 32'd1);
    @(posedge clock); #1;
    up_valid = 1'b1; up_bin = 7'd3; up_value = 32'd1;
    @(negedge clock);
    chk("bp_ready_drop", 65'(up_ready), 65'd0);
    repeat (3) @(negedge clock);
    chk("bp_held", {m_axis_tvalid, m_axis_tdata},
        {1'b1, 64'h0000_0001_0000_0001});
    @(posedge clock); #1 m_axis_tready = 1'b1;
    @(negedge clock);
    chk("bp_ready_back", 65'(up_ready), 65'd1);
    @(posedge clock); #1 up_valid = 1'b0;
    exp_q.push_back(w(9'd3, 32'd1, 1'b1));
    do_flush();
    wait_idle();

    // Timeout
    exp_q.push_back({1'b0, 64'h0000_0007_0000_0004});
    upd(7'd7, 32'd4);
    saw = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clock); #1;
      if (m_axis_tvalid) saw = 1'b1;
    end
    chk("to_not_early", 65'(saw), 65'd0);
    @(posedge clock); #1;
    chk("to_rise", {m_axis_tvalid, m_axis_tdata},
        {1'b1, 64'h0000_0007_0000_0004});
    @(posedge clock); #1;
    chk("to_busy_fall", 65'(busy), 65'd0);

    // Reset mid-operation
    m_axis_tready = 1'b0;
    upd(7'd2, 32'd5);
    upd(7'd6, 32'd8);
    @(posedge clock); #3 reset = 1'b1;
    #1;
    chk("amid_rst", 65'({m_axis_tvalid, word_count}), 65'd0);
    @(posedge clock); #1 reset = 1'b0;
    m_axis_tready = 1'b1;
    exp_q.push_back(w(9'd6, 32'd3, 1'b1));
    upd(7'd6, 32'd3);
    do_flush();
    wait_idle();
    chk("post_rst_count", 65'(word_count), 65'd1);

    repeat (2) @(posedge clock);
    chk("queue_empty", 65'(exp_q.size()), 65'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin_update_tx.md
Name: bin_update_tx

Overview:
- Transmitter side of the binned accumulating stream buffer.
- Accepts (bin index, increment) updates from an upstream event source.
- Coalesces back-to-back updates to the same bin, then emits 64-bit AXI-Stream words to the buffer's slave port.
- Word format: tdata[40:32] = bin, tdata[31:0] = value, all other bits 0.
- Zero values are never sent, because the buffer treats a zero entry as empty.

Parameters:
- ABITS, 7, bin index width; must be ≤ 9 to fit tdata[40:32].
- DBITS, 64, stream data width; fixed at 64.
- VBITS, 32, value width.
- FLUSH_TIMEOUT, 16, idle cycles after which a pending update is emitted; legal range 2..255.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- up_valid  in  1  upstream update valid.
- up_ready  out  1  upstream update accepted when up_valid & up_ready.
- up_bin  in  ABITS  bin index of update.
- up_value  in  VBITS  increment, unsigned.
- flush  in  1  single-cycle request to emit the pending update with tlast.
- m_axis_tvalid  out  1  stream word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DBITS  {23'b0, bin zero-extended to 9 bits, value}.
- m_axis_tlast  out  1  marks the last word of a flush.
- busy  out  1  pending | m_axis_tvalid | flush_latched.
- word_count  out  16  count of completed stream handshakes; wraps modulo 2^16.

Behaviour:
- Reset: already decided — reset reset, asynchronous, active-high; clock clock.
  - Reset clears all state immediately, mid-transfer included.
  - tvalid=0, tlast=0, tdata=0, up_ready=0 during reset, word_count=0, pending=0, age=0, state=IDLE.
  - Any pending or unsent data is discarded.
  - up_ready goes to 1 on the first clock edge after reset deasserts.
- Storage:
  - Pending register: pbin, psum, pending flag.
  - Output register: drives tdata and tlast.
  - "Output free" = !tvalid | tready in the current cycle.
- State machine: IDLE (no pending), ACCUM (pending valid), DRAIN (flush latched).
  - IDLE → ACCUM: accepted update with value ≠ 0. pbin=up_bin, psum=up_value, age=0.
  - Zero-value updates are accepted and dropped; no state change.
  - In ACCUM, accepted update with the same bin:
    - psum = psum + up_value, saturating at 2^VBITS−1.
    - age=0; no word is emitted.
  - In ACCUM, accepted update with a different bin:
    - Legal only if output is free.
    - Pending moves to the output register: tvalid=1, tlast=0 the next cycle.
    - The new update becomes pending.
    - If output is not free, up_ready=0 for that cycle. up_ready is combinational on the bin compare and output state.
  - Timeout: in ACCUM with no accepted update, age increments each cycle.
    - When age reaches FLUSH_TIMEOUT−1 and output is free, pending moves to output (tlast=0) and the state goes to IDLE.
    - If output is not free, age holds at FLUSH_TIMEOUT−1 until it is.
  - flush seen in IDLE with output register empty:
    - No word is emitted.
    - Completes in one cycle with no side effect.
  - flush seen in ACCUM: flush_latched=1, go to DRAIN, up_ready=0.
    - When output is free, pending moves to output with tlast=1 and the state goes to IDLE.
    - If an update is accepted in the same cycle as flush, it is processed first and is included in the drained word.
- AXI-Stream rules:
  - Once tvalid=1, tdata and tlast are held stable until tvalid & tready.
  - tvalid never depends combinationally on tready.
  - Back-to-back words with tvalid continuously high are allowed.
- Latency: a bin change at cycle N gives tvalid=1 at cycle N+1 carrying the old bin.
- Throughput: one word per cycle when bins alternate every cycle and tready=1.
- word_count increments on every tvalid & tready.

Test Plan:
- Coalesce: updates (bin 5, 10), (5, 20), (5, 12) then (9, 1), tready=1.
  - Exactly one word 64'h0000_0005_0000_002A one cycle after the bin-9 accept.
  - No tlast; word_count=1.
- Saturation: (3, 32'hFFFF_FFF0), (3, 32'h20), then flush.
  - Word tdata=64'h0000_0003_FFFF_FFFF, tlast=1.
- Backpressure: tready=0, updates to bins 1, 2, 3 (value 1 each).
  - Word for bin 1 is held stable; up_ready drops on the bin-3 attempt.
  - After tready=1: words for bins 1 then 2, with no loss or duplication.
- Timeout: single update (7, 4), then idle with FLUSH_TIMEOUT=16.
  - tvalid rises 16 cycles after the accept, tdata=64'h0000_0007_0000_0004.
  - busy falls after the handshake.
- Zero/flush-empty: update (4, 0), then flush in IDLE.
  - No word emitted; word_count stays 0; busy stays 0.
- Reset mid-operation: pending (6, 8), output holding bin 2 with tready=0; assert reset asynchronously.
  - tvalid=0 and word_count=0 immediately.
  - After release, a new update to bin 6 starts a fresh sum (value 3 gives 3, not 11).
